uart_rx_capture: RTL and testbench



---
 rtl/uart_pkg.sv | 33 +++
 rtl/uart_sync_fifo.sv | 58 +++++
 rtl/uart_rx_capture.sv | 212 +++++++++++++++++++++
 tb/tb_uart_rx_capture.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types for the UART receive capture path.
// Optional parity support is enabled with the UART_RX_PARITY_EN macro.
package uart_pkg;

  localparam int UART_DATA_BITS = 8;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_RX_PARITY_EN
    PARITY,
`endif
    STOP
  } uart_rx_state_e;

  typedef struct packed {
    logic                      frame_err;
`ifdef UART_RX_PARITY_EN
    logic                      parity_err;
`endif
    logic [UART_DATA_BITS-1:0] data;
  } uart_rx_entry_t;

  localparam int UART_ENTRY_W = $bits(uart_rx_entry_t);

  // Even parity: the data bits and the parity bit together must XOR to zero.
  function automatic logic even_parity_err(input logic [UART_DATA_BITS-1:0] data,
                                           input logic par_bit);
    return (^data) ^ par_bit;
  endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Small synchronous FIFO used to buffer received UART bytes.
// A push while full is ignored unless a pop happens in the same cycle; the
// parent decides whether a byte was dropped. The head entry reads as zero
// while the FIFO is empty.
module uart_sync_fifo #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         data_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [PTR_W:0]   count_q;
  logic             wr_en;
  logic             rd_en;

  assign full_o  = (count_q == (PTR_W+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign wr_en   = push_i && (!full_o || pop_i);
  assign rd_en   = pop_i && !empty_o;
  assign data_o  = empty_o ? '0 : mem_q[rd_ptr_q];

  // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (wr_en) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (rd_en) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({wr_en, rd_en})
        2'b10:   count_q <= count_q + (PTR_W+1)'(1);
        2'b01:   count_q <= count_q - (PTR_W+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage array; contents need no reset because the head is masked when empty.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/uart_rx_capture.sv
// 8N1 UART receiver with a byte FIFO and a valid/ready output stream.
// Define UART_RX_PARITY_EN to receive an even parity bit between the data
// and stop bits and report it on out_parity_err.
module uart_rx_capture
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868,
  parameter int FIFO_DEPTH   = 8,
  parameter int CNT_W        = $clog2(CLKS_PER_BIT)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          rxd,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [7:0]                    out_data,
  output logic                          out_frame_err,
`ifdef UART_RX_PARITY_EN
  output logic                          out_parity_err,
`endif
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow,
  input  logic                          overflow_clr,
  output logic                          busy
);

  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [2:0]       IDX_LAST  = 3'(UART_DATA_BITS - 1);

  logic                       rxd_meta_q;
  logic                       rxd_s_q;

  uart_rx_state_e             state_q, state_d;
  logic [CNT_W-1:0]           cnt_q, cnt_d;
  logic [2:0]                 bit_idx_q, bit_idx_d;
  logic [UART_DATA_BITS-1:0]  shreg_q, shreg_d;
  logic                       armed_q, armed_d;
`ifdef UART_RX_PARITY_EN
  logic                       parity_err_q, parity_err_d;
`endif
  logic                       overflow_q, overflow_d;

  logic                       push_req;
  uart_rx_entry_t             push_entry;
  uart_rx_entry_t             head_entry;
  logic                       fifo_push;
  logic                       fifo_pop;
  logic                       fifo_full;
  logic                       fifo_empty;

  // Two-flop synchroniser; idles high so reset does not look like a start bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      rxd_meta_q <= 1'b1;
      rxd_s_q    <= 1'b1;
    end else begin
      rxd_meta_q <= rxd;
      rxd_s_q    <= rxd_meta_q;
    end
  end

  // FSM state and bit-timing datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      bit_idx_q    <= '0;
      shreg_q      <= '0;
      armed_q      <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err_q <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      bit_idx_q    <= bit_idx_d;
      shreg_q      <= shreg_d;
      armed_q      <= armed_d;
`ifdef UART_RX_PARITY_EN
      parity_err_q <= parity_err_d;
`endif
    end
  end

  // Next-state logic; armed_q blocks a held-low line (break) from re-triggering
  // until the line has been seen high again.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    bit_idx_d    = bit_idx_q;
    shreg_d      = shreg_q;
    armed_d      = armed_q || rxd_s_q;
`ifdef UART_RX_PARITY_EN
    parity_err_d = parity_err_q;
`endif
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (armed_q && !rxd_s_q) begin
          state_d = START;
        end
      end
      START: begin
        if (cnt_q == HALF_LAST) begin
          cnt_d = '0;
          if (!rxd_s_q) begin
            state_d   = DATA;
            bit_idx_d = '0;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DATA: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d              = '0;
          shreg_d[bit_idx_q] = rxd_s_q;
          if (bit_idx_q == IDX_LAST) begin
`ifdef UART_RX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d        = '0;
          parity_err_d = even_parity_err(shreg_q, rxd_s_q);
          state_d      = STOP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
`endif
      STOP: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d   = '0;
          state_d = IDLE;
          armed_d = rxd_s_q;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // FSM outputs: the completed entry is pushed in the stop-bit sample cycle.
  always_comb begin
    push_req             = (state_q == STOP) && (cnt_q == BIT_LAST);
    push_entry           = '0;
    push_entry.frame_err = !rxd_s_q;
    push_entry.data      = shreg_q;
`ifdef UART_RX_PARITY_EN
    push_entry.parity_err = parity_err_q;
`endif
    busy                 = (state_q != IDLE);
  end

  assign fifo_pop  = out_valid && out_ready;
  assign fifo_push = push_req && (!fifo_full || fifo_pop);

  // Sticky overflow flag; a new drop wins over a simultaneous clear.
  always_comb begin
    overflow_d = overflow_q;
    if (overflow_clr) overflow_d = 1'b0;
    if (push_req && fifo_full && !fifo_pop) overflow_d = 1'b1;
  end

  // Overflow register.
  always_ff @(posedge clk) begin
    if (rst) overflow_q <= 1'b0;
    else     overflow_q <= overflow_d;
  end

  uart_sync_fifo #(
    .WIDTH (UART_ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (fifo_push),
    .data_i  (push_entry),
    .pop_i   (fifo_pop),
    .data_o  (head_entry),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  assign out_valid     = !fifo_empty;
  assign out_data      = head_entry.data;
  assign out_frame_err = head_entry.frame_err;
`ifdef UART_RX_PARITY_EN
  assign out_parity_err = head_entry.parity_err;
`endif
  assign overflow      = overflow_q;

endmodule

// File: tb/tb_uart_rx_capture.sv
// Self-checking bench for uart_rx_capture: serial frames are driven on rxd,
// the expected bytes go into a queue and a monitor checks each accepted beat.
// Follows UART_RX_PARITY_EN if it is defined for the build.
module tb_uart_rx_capture;

  localparam int CPB   = 16;
  localparam int DEPTH = 4;
`ifdef UART_RX_PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif
  // Sync (2) + start detect (1) + half a bit to start centre, then one full
  // bit to each later bit centre up to the stop bit, whose sample writes the FIFO.
  localparam int PUSH_LAT = 3 + CPB / 2 + (FRAME_BITS - 1) * CPB;

  typedef struct {
    logic [7:0] data;
    logic       ferr;
  } exp_t;

  logic       clk;
  logic       rst;
  logic       rxd;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic       out_frame_err;
`ifdef UART_RX_PARITY_EN
  logic       out_parity_err;
`endif
  logic [2:0] fifo_count;
  logic       overflow;
  logic       overflow_clr;
  logic       busy;

  exp_t expQ[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   cyc = 0;
  int   startCyc = 0;
  int   firstValidCyc = -1;
  int   maxCount = 0;
  int   busyCnt = 0;
  bit   randReady = 0;

  uart_rx_capture #(
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (DEPTH)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .rxd            (rxd),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_data       (out_data),
    .out_frame_err  (out_frame_err),
`ifdef UART_RX_PARITY_EN
    .out_parity_err (out_parity_err),
`endif
    .fifo_count     (fifo_count),
    .overflow       (overflow),
    .overflow_clr   (overflow_clr),
    .busy           (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Free-running cycle counter used for latency measurement.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, wanted 0x%0h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  task automatic expectBeat(input logic [7:0] d, input logic ferr);
    exp_t e;
    e.data = d;
    e.ferr = ferr;
    expQ.push_back(e);
  endtask

  // One clock step: sample observers just after the edge, optionally jitter ready.
  task automatic tick();
    @(posedge clk);
    #1;
    if (randReady) out_ready = 1'($urandom_range(0, 1));
    if (int'(fifo_count) > maxCount) maxCount = int'(fifo_count);
    if (out_valid && firstValidCyc < 0) firstValidCyc = cyc;
    if (busy) busyCnt++;
  endtask

  task automatic idle(input int n);
    rxd = 1'b1;
    repeat (n) tick();
  endtask

  // Drive the first nBits bits of a frame: start, data LSB first, [parity], stop.
  task automatic applyStimulus(input logic [7:0] d, input logic stopBit, input int nBits);
    logic frameBits [11];
    frameBits[0] = 1'b0;
    for (int i = 0; i < 8; i++) frameBits[1+i] = d[i];
    frameBits[9]  = ^d;
    frameBits[10] = 1'b1;
    frameBits[FRAME_BITS-1] = stopBit;
    for (int b = 0; b < nBits; b++) begin
      for (int c = 0; c < CPB; c++) begin
        tick();
        if (b == 0 && c == 0) startCyc = cyc;
        rxd = frameBits[b];
      end
    end
  endtask

  task automatic waitDrain();
    int guard = 0;
    while (expQ.size() > 0 && guard < 3000) begin
      tick();
      guard++;
    end
    checkOutput("drain_queue_empty", expQ.size(), 0);
  endtask

  // Scoreboard monitor: every accepted beat must match the oldest expectation.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (expQ.size() == 0) begin
        vectors++;
        miscompares++;
        $display("[TB] FAIL unexpected_beat: got data 0x%0h ferr %0b, wanted no beat", out_data, out_frame_err);
      end else begin
        exp_t e;
        e = expQ.pop_front();
        checkOutput("beat_data", out_data, e.data);
        checkOutput("beat_frame_err", out_frame_err, e.ferr);
`ifdef UART_RX_PARITY_EN
        checkOutput("beat_parity_err", out_parity_err, 0);
`endif
      end
    end
  end

  // Global watchdog so the bench can never hang.
  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: got timeout, wanted completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [7:0] d;
    bit         good;
    rxd          = 1'b1;
    rst          = 1'b1;
    out_ready    = 1'b0;
    overflow_clr = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_out_valid", out_valid, 0);
    checkOutput("rst_out_data", out_data, 0);
    checkOutput("rst_frame_err", out_frame_err, 0);
    checkOutput("rst_fifo_count", fifo_count, 0);
    checkOutput("rst_overflow", overflow, 0);
    checkOutput("rst_busy", busy, 0);
    rst = 1'b0;
    idle(5);

    $display("[TB] single frame 0xA5");
    out_ready = 1'b1;
    firstValidCyc = -1;
    expectBeat(8'hA5, 1'b0);
    applyStimulus(8'hA5, 1'b1, FRAME_BITS);
    idle(CPB);
    checkOutput("a5_valid_latency", firstValidCyc - startCyc, PUSH_LAT);
    waitDrain();

    $display("[TB] back-to-back 0x00 0xFF 0x55");
    maxCount = 0;
    expectBeat(8'h00, 1'b0);
    expectBeat(8'hFF, 1'b0);
    expectBeat(8'h55, 1'b0);
    applyStimulus(8'h00, 1'b1, FRAME_BITS);
    applyStimulus(8'hFF, 1'b1, FRAME_BITS);
    applyStimulus(8'h55, 1'b1, FRAME_BITS);
    idle(CPB);
    checkOutput("b2b_count_peak", maxCount, 1);
    waitDrain();

    $display("[TB] start-bit glitch");
    tick();
    rxd = 1'b0;
    busyCnt = 0;
    repeat (4) tick();
    idle(30);
    checkOutput("glitch_busy_le10", busyCnt <= 10, 1);
    checkOutput("glitch_busy_seen", busyCnt > 0, 1);
    checkOutput("glitch_no_push", fifo_count, 0);

    $display("[TB] framing error then good frame");
    expectBeat(8'h3C, 1'b1);
    applyStimulus(8'h3C, 1'b0, FRAME_BITS);
    idle(2 * CPB);
    expectBeat(8'h12, 1'b0);
    applyStimulus(8'h12, 1'b1, FRAME_BITS);
    waitDrain();

    $display("[TB] break condition");
    expectBeat(8'h00, 1'b1);
    applyStimulus(8'h00, 1'b0, FRAME_BITS);
    repeat (20 * CPB) tick();
    checkOutput("break_no_retrigger", busy, 0);
    idle(2 * CPB);
    waitDrain();

    $display("[TB] overflow with out_ready low");
    out_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      d = 8'($urandom_range(0, 255));
      if (i < DEPTH) expectBeat(d, 1'b0);
      applyStimulus(d, 1'b1, FRAME_BITS);
    end
    idle(4);
    checkOutput("ovf_fifo_count", fifo_count, DEPTH);
    checkOutput("ovf_flag_set", overflow, 1);
    tick();
    overflow_clr = 1'b1;
    tick();
    overflow_clr = 1'b0;
    checkOutput("ovf_flag_cleared", overflow, 0);
    checkOutput("ovf_count_held", fifo_count, DEPTH);
    out_ready = 1'b1;
    waitDrain();

    $display("[TB] reset mid-frame");
    out_ready = 1'b0;
    applyStimulus(8'h33, 1'b1, FRAME_BITS);
    idle(4);
    checkOutput("pre_rst_count", fifo_count, 1);
    applyStimulus(8'h81, 1'b1, 4);
    tick();
    rst = 1'b1;
    rxd = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    checkOutput("midrst_fifo_count", fifo_count, 0);
    checkOutput("midrst_busy", busy, 0);
    checkOutput("midrst_out_valid", out_valid, 0);
    idle(2 * CPB);
    out_ready = 1'b1;
    expectBeat(8'h7E, 1'b0);
    applyStimulus(8'h7E, 1'b1, FRAME_BITS);
    waitDrain();

    $display("[TB] randomized frames");
    randReady = 1;
    for (int i = 0; i < 12; i++) begin
      d    = 8'($urandom_range(0, 255));
      good = ($urandom_range(0, 9) != 0);
      expectBeat(d, !good);
      applyStimulus(d, good, FRAME_BITS);
      if (good) idle($urandom_range(0, 20));
      else      idle(CPB + $urandom_range(0, 20));
    end
    idle(CPB);
    randReady = 0;
    out_ready = 1'b1;
    waitDrain();
    checkOutput("rand_no_overflow", overflow, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
